// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for a downstream ALU.
// One button press per operand, then opcode, then the result is shown.
module alu_operand_sequencer #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] SwIn,
  input  logic         FlagSw,
  input  logic         LoadBtn,
  input  logic [n-1:0] ALUResultIn,
  input  logic         CIn,
  input  logic         ZIn,
  output logic [n-1:0] ALUA,
  output logic [n-1:0] ALUB,
  output logic [3:0]   ALUControl,
  output logic         ALUFlagIn,
  output logic [n-1:0] ResultOut,
  output logic         COut,
  output logic         ZOut,
  output logic [2:0]   State,
  output logic         Done,
  output logic         Err
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t state, state_nx;
  logic   sync1, sync2, sync3;
  logic   load;
  logic   op_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= LoadBtn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // rising edge of the synchronized button; a held press pulses once
  assign load  = sync2 & ~sync3;
  assign op_ok = (SwIn[3:0] <= 4'h9);

  always_comb begin
    state_nx = S_A;
    unique case (state)
      S_A:     state_nx = load ? S_B : S_A;
      S_B:     state_nx = load ? S_OP : S_B;
      S_OP:    state_nx = (load && op_ok) ? S_EXEC : S_OP;
      S_EXEC:  state_nx = S_SHOW;
      S_SHOW:  state_nx = load ? S_A : S_SHOW;
      default: state_nx = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUA       <= '0;
      ALUB       <= '0;
      ALUControl <= '0;
      ALUFlagIn  <= 1'b0;
      ResultOut  <= '0;
      COut       <= 1'b0;
      ZOut       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      unique case (state)
        S_A: if (load) ALUA <= SwIn;
        S_B: if (load) ALUB <= SwIn;
        S_OP: begin
          if (load && op_ok) begin
            ALUControl <= SwIn[3:0];
            ALUFlagIn  <= FlagSw;
            Err        <= 1'b0;
          end else if (load) begin
            Err <= 1'b1;
          end
        end
        S_EXEC: begin
          ResultOut <= ALUResultIn;
          COut      <= CIn;
          ZOut      <= ZIn;
          Done      <= 1'b1;
        end
        S_SHOW: if (load) Done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small add/sub ALU model.
// Outputs are sampled on the falling clock edge.
module tb_alu_operand_sequencer;

  localparam int n = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [n-1:0] SwIn = '0;
  logic         FlagSw = 1'b0;
  logic         LoadBtn = 1'b0;
  logic [n-1:0] ALUResultIn;
  logic         CIn, ZIn;
  logic [n-1:0] ALUA, ALUB, ResultOut;
  logic [3:0]   ALUControl;
  logic         ALUFlagIn, COut, ZOut, Done, Err;
  logic [2:0]   State;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.n(n)) dut (
    .clk(clk), .rst_n(rst_n), .SwIn(SwIn), .FlagSw(FlagSw),
    .LoadBtn(LoadBtn), .ALUResultIn(ALUResultIn), .CIn(CIn), .ZIn(ZIn),
    .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl),
    .ALUFlagIn(ALUFlagIn), .ResultOut(ResultOut), .COut(COut),
    .ZOut(ZOut), .State(State), .Done(Done), .Err(Err)
  );

  // ALU model: op 2 = add, op 7 = subtract (carry = borrow)
  logic [n:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (ALUControl)
      4'd2:    alu_wide = {1'b0, ALUA} + {1'b0, ALUB};
      4'd7:    alu_wide = {1'b0, ALUA} - {1'b0, ALUB};
      default: alu_wide = '0;
    endcase
  end
  assign ALUResultIn = alu_wide[n-1:0];
  assign CIn = alu_wide[n];
  assign ZIn = (alu_wide[n-1:0] == '0);

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Raise the button and wait until the first register update is visible.
  task automatic press(input logic [n-1:0] v, input logic f);
    @(negedge clk);
    SwIn = v;
    FlagSw = f;
    LoadBtn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_btn();
    @(negedge clk);
    LoadBtn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_alua", 8'(ALUA), 8'd0);
    chk("rst_done", 8'(Done), 8'd0);
    chk("rst_err", 8'(Err), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    press(4'd3, 1'b0);
    chk("basic_a", 8'(ALUA), 8'd3);
    chk("basic_st_b", 8'(State), 8'd1);
    release_btn();
    press(4'd5, 1'b0);
    chk("basic_b", 8'(ALUB), 8'd5);
    chk("basic_st_op", 8'(State), 8'd2);
    release_btn();
    press(4'd2, 1'b0);
    chk("basic_ctl", 8'(ALUControl), 8'd2);
    chk("basic_st_exec", 8'(State), 8'd3);
    chk("basic_done_early", 8'(Done), 8'd0);
    release_btn();
    chk("basic_st_show", 8'(State), 8'd4);
    chk("basic_done", 8'(Done), 8'd1);
    chk("basic_res", 8'(ResultOut), 8'd8);
    chk("basic_c", 8'(COut), 8'd0);
    chk("basic_z", 8'(ZOut), 8'd0);
    chk("basic_flag", 8'(ALUFlagIn), 8'd0);
  endtask

  task automatic test_show_exit();
    press(4'd0, 1'b0);
    chk("show_done", 8'(Done), 8'd0);
    chk("show_state", 8'(State), 8'd0);
    chk("show_res_held", 8'(ResultOut), 8'd8);
    release_btn();
  endtask

  task automatic test_hold();
    @(negedge clk);
    SwIn = 4'd6;
    LoadBtn = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_a_early", 8'(ALUA), 8'd3);
    @(negedge clk);
    chk("hold_a", 8'(ALUA), 8'd6);
    chk("hold_state", 8'(State), 8'd1);
    SwIn = 4'd1;
    repeat (17) @(negedge clk);
    chk("hold_state_stay", 8'(State), 8'd1);
    chk("hold_b_kept", 8'(ALUB), 8'd5);
    release_btn();
    press(4'd9, 1'b0);
    chk("hold_b9", 8'(ALUB), 8'd9);
    release_btn();
  endtask

  task automatic test_err();
    press(4'hC, 1'b1);
    chk("err_set", 8'(Err), 8'd1);
    chk("err_state", 8'(State), 8'd2);
    chk("err_ctl_kept", 8'(ALUControl), 8'd2);
    chk("err_flag_kept", 8'(ALUFlagIn), 8'd0);
    release_btn();
    press(4'h7, 1'b1);
    chk("err_clr", 8'(Err), 8'd0);
    chk("err_ctl7", 8'(ALUControl), 8'd7);
    chk("err_st_exec", 8'(State), 8'd3);
    release_btn();
    chk("sub_state", 8'(State), 8'd4);
    chk("sub_res", 8'(ResultOut), 8'hD);
    chk("sub_c", 8'(COut), 8'd1);
    chk("sub_z", 8'(ZOut), 8'd0);
    chk("sub_flag", 8'(ALUFlagIn), 8'd1);
    press(4'd0, 1'b0);
    chk("sub_exit", 8'(State), 8'd0);
    release_btn();
  endtask

  task automatic test_async_reset();
    press(4'd9, 1'b0);
    chk("ar_a9", 8'(ALUA), 8'd9);
    chk("ar_st_b", 8'(State), 8'd1);
    release_btn();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 8'(State), 8'd0);
    chk("ar_a", 8'(ALUA), 8'd0);
    chk("ar_b", 8'(ALUB), 8'd0);
    chk("ar_ctl", 8'(ALUControl), 8'd0);
    chk("ar_flag", 8'(ALUFlagIn), 8'd0);
    chk("ar_res", 8'(ResultOut), 8'd0);
    chk("ar_c", 8'(COut), 8'd0);
    chk("ar_z", 8'(ZOut), 8'd0);
    chk("ar_done", 8'(Done), 8'd0);
    chk("ar_err", 8'(Err), 8'd0);
  endtask

  task automatic test_reset_held_btn();
    @(negedge clk);
    SwIn = 4'd4;
    LoadBtn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rh_a", 8'(ALUA), 8'd4);
    chk("rh_state", 8'(State), 8'd1);
    repeat (5) @(negedge clk);
    chk("rh_state_stay", 8'(State), 8'd1);
    release_btn();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_show_exit();
    test_hold();
    test_err();
    test_async_reset();
    test_reset_held_btn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL have parameter n, default 4, giving the operand and result width; n SHALL be 4 or greater.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 SwIn  input  n  operand or opcode entry value (opcode uses SwIn[3:0]).
REQ-006 FlagSw  input  1  flag-in entry value, captured together with the opcode.
REQ-007 LoadBtn  input  1  asynchronous load button, active-high.
REQ-008 ALUResultIn  input  n  result returned by the downstream ALU.
REQ-009 CIn, ZIn  input  1 each  carry and zero flags returned by the ALU.
REQ-010 ALUA, ALUB  output  n each  registered operands driven to the ALU.
REQ-011 ALUControl  output  4  registered opcode driven to the ALU.
REQ-012 ALUFlagIn  output  1  registered flag-in driven to the ALU.
REQ-013 ResultOut  output  n  captured ALU result.
REQ-014 COut, ZOut  output  1 each  captured carry and zero flags.
REQ-015 State  output  3  current FSM state encoding.
REQ-016 Done  output  1  high while a captured result is being shown.
REQ-017 Err  output  1  high after an invalid opcode entry attempt.

Function
REQ-018 LoadBtn SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, producing one internal load pulse per press.
REQ-019 The load pulse SHALL be high for exactly one cycle, in the cycle after the second synchronizer edge that samples LoadBtn high; a held button SHALL produce no further pulses.
REQ-020 FSM states and encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4; codes 5-7 SHALL go to S_A on the next edge.
REQ-021 S_A, on load pulse: ALUA<=SwIn; next state S_B.
REQ-022 S_B, on load pulse: ALUB<=SwIn; next state S_OP.
REQ-023 S_OP, on load pulse with SwIn[3:0]<=4'h9: ALUControl<=SwIn[3:0], ALUFlagIn<=FlagSw, Err<=0; next state S_EXEC.
REQ-024 S_OP, on load pulse with SwIn[3:0]>4'h9: ALUControl and ALUFlagIn unchanged, Err<=1; state stays S_OP.
REQ-025 S_EXEC SHALL last exactly one cycle (ALU settle time); on its closing edge ResultOut<=ALUResultIn, COut<=CIn, ZOut<=ZIn, Done<=1; next state S_SHOW.
REQ-026 S_SHOW, on load pulse: Done<=0; next state S_A; ResultOut, COut, ZOut and the ALU drive registers SHALL hold until overwritten.
REQ-027 In any state, no load pulse SHALL mean no register change; a pulse arriving during S_EXEC SHALL be ignored.
REQ-028 Latency from the first clk edge sampling LoadBtn high to the register update SHALL be 3 edges.
REQ-029 Latency from the S_OP load edge to Done=1 SHALL be 1 further edge.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 rst_n low SHALL immediately force the following, independent of clk, including mid-sequence:
- State=S_A.
- ALUA=0, ALUB=0, ALUControl=0, ALUFlagIn=0.
- ResultOut=0, COut=0, ZOut=0.
- Done=0, Err=0.
- Synchronizer and edge-detect flops cleared.
REQ-032 After rst_n rises, a LoadBtn already high SHALL produce one load pulse.

Verification
REQ-033 Load 3, 5, opcode 2 with FlagSw=0; ALU model returns ResultOut=8, CIn=0, ZIn=0 -> ALUA=3, ALUB=5, ALUControl=2, Done=1, ResultOut=8, State=4.
REQ-034 Hold LoadBtn high for 20 cycles in S_A with SwIn=6 -> ALUA=6 three edges after the first high sample, State=1, and no further state change.
REQ-035 In S_OP press with SwIn=4'hC -> Err=1, State=2, ALUControl unchanged; then press with SwIn=4'h7 -> Err=0, ALUControl=7, State=3.
REQ-036 Assert rst_n low asynchronously while in S_B with ALUA=9 -> all outputs 0 and State=0 before the next clk edge.
REQ-037 In S_SHOW with ResultOut=8, press LoadBtn -> Done=0, State=0, ResultOut=8 held.
